clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Measures the period and high time of a slow clock, counted in clk_in cycles. The slow clock is typically the output of the variable clock divider.
- Closes the loop on the divider: the LED controller and its benches use it to confirm the programmed divisor actually produced the expected output rate and duty.
- Sits in the clk_in domain. meas_clk is treated as asynchronous and synchronised internally.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- SYNC_STAGES, 2, number of flops in the meas_clk synchroniser (legal values 2 or 3).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset, sampled on rising edge of clk_in).
- sleep  input  1  1 = freeze measurement; edges ignored, outputs held.
- meas_clk  input  1  clock under measurement; asynchronous to clk_in.
- period  output  CNT_W  clk_in cycles between the last two meas_clk rising edges.
- high_time  output  CNT_W  clk_in cycles meas_clk was high within that period.
- period_valid  output  1  one-cycle pulse when period/high_time update.
- stalled  output  1  1 = no rising edge seen within 2^CNT_W-1 cycles.

Behaviour:
- Reset (reset==0 at an edge): period=0, high_time=0, period_valid=0, stalled=0, synchroniser and edge flops=0, counter=0, state=ACQUIRE. Reset takes priority over sleep and all other events.
- Input path: SYNC_STAGES-flop synchroniser, then one edge-detect flop.
  - rise/fall are single-cycle pulses derived from the synchronised signal.
  - Fixed latency from meas_clk edge to pulse is SYNC_STAGES+1 cycles. This latency does not bias measurements.
- Minimum measurable period: 2 clk_in cycles. Shorter pulses are undefined.
- States: ACQUIRE, MEASURE.
- ACQUIRE:
  - counter idle; fall is ignored.
  - On rise: counter<=1, hi_lat<=0, go to MEASURE. No output update.
- MEASURE, every cycle:
  - counter<=counter+1, saturating at MAX=2^CNT_W-1.
  - On fall: hi_lat<=counter (counter equals cycles since the rise).
  - On rise:
    - period<=counter and high_time<=hi_lat, so both are visible the cycle after rise.
    - period_valid=1 for exactly that one cycle.
    - stalled<=0, counter<=1, remain in MEASURE.
  - If counter==MAX and no rise this cycle: stalled<=1, go to ACQUIRE. period/high_time keep their last values.
  - A rise in the same cycle as counter==MAX is a valid measurement (period=MAX); no stall.
- sleep==1:
  - counter, state machine and outputs frozen; rise/fall discarded.
  - period_valid forced 0; synchroniser keeps running.
  - On the cycle sleep returns to 0, the state machine enters ACQUIRE and discards the partial measurement. stalled holds its value.
- period_valid is never asserted two cycles in a row.

Optional Feature:
- Macro: PERIOD_METER_AVG_EN.
- Defined:
  - period reports the mean of the last 4 measured periods: a CNT_W+2-bit running sum over a 4-entry history, output = sum>>2, truncated.
  - period_valid asserts only once 4 periods have been captured since the last ACQUIRE entry. The first 3 rises after ACQUIRE update the history silently.
  - high_time is still single-period.
  - Entry to ACQUIRE (stall, sleep release, reset) clears the history and fill count.
- Undefined: single-period behaviour exactly as above; no history storage is synthesised.

Test Plan:
- All cases use a 5 us clk_in period, CNT_W=8, macro undefined unless stated.
- Steady clock: meas_clk period 10 clk_in cycles, 5 high -> after the second rise, period=10, high_time=5, period_valid pulses every 10 cycles, stalled=0.
- Duty/step: meas_clk 3 high / 7 low, then switch to 1 high / 3 low -> period=10/high_time=3, then period=4/high_time=1 from the second new-rate rise. No stale or mixed values.
- Stall and recovery: hold meas_clk low after a valid measurement -> stalled=1 exactly 255 cycles after the last rise, period retains 10. Restart meas_clk -> stalled clears with the first period_valid (second rise).
- Sleep mid-measurement: assert sleep for 7 cycles mid-period -> no period_valid during sleep, outputs unchanged. First valid after release requires two fresh rises and reports the true period.
- Reset mid-operation: pull reset low for one cycle during MEASURE -> next cycle period=0, high_time=0, stalled=0, period_valid=0, state ACQUIRE. Measurements resume on the second rise.
- PERIOD_METER_AVG_EN defined: periods 8, 8, 12, 12 -> single period_valid with period=10 on the fourth capture. A fifth period of 16 -> period=12.

Source files
------------

// File: rtl/clock_period_meter_if.sv
// clock_period_meter_if
//   Result bundle produced by clock_period_meter.
//   master : the meter, drives the measurement results
//   slave  : the consumer (LED controller, benches)
// Signals:
//   period        [CNT_W] clk_in cycles between the last two meas_clk rises
//   high_time     [CNT_W] clk_in cycles meas_clk was high within that period
//   period_valid  one-cycle pulse when period/high_time update
//   stalled       no meas_clk rise seen within 2^CNT_W-1 cycles
interface clock_period_meter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             stalled;

    modport master (
        output period,
        output high_time,
        output period_valid,
        output stalled
    );

    modport slave (
        input period,
        input high_time,
        input period_valid,
        input stalled
    );
endinterface

// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures period and high time of an asynchronous slow clock (meas_clk),
//   counted in clk_in cycles. meas_clk passes through a SYNC_STAGES-flop
//   synchroniser and an edge-detect flop before reaching the state machine.
// Ports:
//   clk_in    system clock, all logic on its rising edge
//   reset     synchronous reset, active-low
//   sleep     1 = freeze measurement, outputs held, period_valid forced 0
//   meas_clk  clock under measurement (asynchronous)
//   mon       clock_period_meter_if.master: period, high_time,
//             period_valid, stalled
// Optional feature:
//   PERIOD_METER_AVG_EN - when defined, period reports the truncated mean of
//   the last 4 measured periods and period_valid waits for a full history.
module clock_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  sleep,
    input  logic                  meas_clk,
    clock_period_meter_if.master  mon
);

    typedef enum logic {
        ACQUIRE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   sleep_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       hi_lat_q;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_time_q;
    logic                   valid_q;
    logic                   stalled_q;

    logic                   meas_s;
    logic                   rise;
    logic                   fall;
    logic                   active;
    logic                   capture;
    logic                   acq_entry;
    logic                   cap_valid_d;
    logic [CNT_W-1:0]       cap_period_d;

    assign meas_s = sync_q[SYNC_STAGES-1];
    assign rise   = meas_s & ~edge_q;
    assign fall   = ~meas_s & edge_q;

    // The cycle sleep drops is spent re-entering ACQUIRE, not processing edges.
    assign active    = ~sleep & ~sleep_q;
    assign capture   = active & (state_q == MEASURE) & rise;
    assign acq_entry = (~sleep & sleep_q)
                     | (active & (state_q == MEASURE) & ~rise & (cnt_q == CNT_MAX));

`ifdef PERIOD_METER_AVG_EN
    logic [CNT_W-1:0] hist_q [4];
    logic [CNT_W+1:0] sum_q;
    logic [CNT_W+1:0] sum_d;
    logic [2:0]       fill_q;

    // Running sum: drop the oldest entry, add the period just measured.
    assign sum_d        = sum_q - {2'b00, hist_q[3]} + {2'b00, cnt_q};
    assign cap_period_d = sum_d[CNT_W+1:2];
    assign cap_valid_d  = (fill_q >= 3'd3);

    always_ff @(posedge clk_in) begin
        if (!reset || acq_entry) begin
            for (int unsigned i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            sum_q  <= '0;
            fill_q <= '0;
        end else if (capture) begin
            hist_q[0] <= cnt_q;
            for (int unsigned i = 1; i < 4; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            sum_q <= sum_d;
            if (fill_q != 3'd4) begin
                fill_q <= fill_q + 3'd1;
            end
        end
    end
`else
    assign cap_period_d = cnt_q;
    assign cap_valid_d  = 1'b1;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= ACQUIRE;
            sync_q      <= '0;
            edge_q      <= 1'b0;
            sleep_q     <= 1'b0;
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            // Synchroniser and edge flop keep running through sleep.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], meas_clk};
            edge_q  <= meas_s;
            sleep_q <= sleep;
            valid_q <= 1'b0;

            if (sleep) begin
                // Hold everything; edges are discarded.
            end else if (sleep_q) begin
                state_q  <= ACQUIRE;
                cnt_q    <= '0;
                hi_lat_q <= '0;
            end else begin
                case (state_q)
                    ACQUIRE: begin
                        if (rise) begin
                            cnt_q    <= {{(CNT_W-1){1'b0}}, 1'b1};
                            hi_lat_q <= '0;
                            state_q  <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            if (cap_valid_d) begin
                                period_q    <= cap_period_d;
                                high_time_q <= hi_lat_q;
                                valid_q     <= 1'b1;
                            end
                            stalled_q <= 1'b0;
                            cnt_q     <= {{(CNT_W-1){1'b0}}, 1'b1};
                            hi_lat_q  <= '0;
                        end else if (cnt_q == CNT_MAX) begin
                            stalled_q <= 1'b1;
                            state_q   <= ACQUIRE;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (fall) begin
                                hi_lat_q <= cnt_q;
                            end
                        end
                    end
                    default: state_q <= ACQUIRE;
                endcase
            end
        end
    end

    assign mon.period       = period_q;
    assign mon.high_time    = high_time_q;
    assign mon.period_valid = valid_q;
    assign mon.stalled      = stalled_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter
//   Directed bench for clock_period_meter with CNT_W=8, 5 us clk_in.
//   meas_clk is driven on the falling edge of clk_in; outputs are sampled on
//   the falling edge. Build with PERIOD_METER_AVG_EN to run the averaging case.
`timescale 1ns/1ps
module tb_clock_period_meter;

    localparam int CNT_W = 8;

    logic clk_in = 1'b0;
    logic reset;
    logic sleep;
    logic meas_clk;

    always #2500 clk_in = ~clk_in;

    clock_period_meter_if #(.CNT_W(CNT_W)) mon_if ();

    clock_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .sleep    (sleep),
        .meas_clk (meas_clk),
        .mon      (mon_if)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    typedef struct {
        int p;
        int h;
        int c;
    } cap_t;

    cap_t caps[$];
    logic prev_valid   = 1'b0;
    logic prev_stalled = 1'b0;
    int   stall_cyc    = -1;

    // Captured results of the long steady/duty/step run.
    int exp_p [12] = '{10, 10, 10, 10, 10, 10, 10, 10, 4, 4, 4, 10};
    int exp_h [12] = '{ 5,  5,  5,  5,  5,  3,  3,  3, 1, 1, 1,  5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic gen(input int unsigned h, input int unsigned l);
        meas_clk = 1'b1;
        repeat (h) @(negedge clk_in);
        meas_clk = 1'b0;
        repeat (l) @(negedge clk_in);
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (mon_if.period_valid === 1'b1) begin
            chk("no_back_to_back", 32'(prev_valid), 32'd0);
            chk("stalled_low_on_valid", 32'(mon_if.stalled), 32'd0);
            caps.push_back('{p: int'(mon_if.period), h: int'(mon_if.high_time), c: cyc});
        end
        if (mon_if.stalled === 1'b1 && prev_stalled === 1'b0) begin
            stall_cyc = cyc;
        end
        prev_valid   = mon_if.period_valid;
        prev_stalled = mon_if.stalled;
    end

    initial begin
        reset    = 1'b0;
        sleep    = 1'b0;
        meas_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_period", 32'(mon_if.period), 32'd0);
        chk("rst_high", 32'(mon_if.high_time), 32'd0);
        chk("rst_valid", 32'(mon_if.period_valid), 32'd0);
        chk("rst_stalled", 32'(mon_if.stalled), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk_in);

`ifdef PERIOD_METER_AVG_EN
        // Periods 8, 8, 12, 12 then 16.
        caps.delete();
        gen(4, 4);
        gen(4, 4);
        gen(6, 6);
        gen(6, 6);
        chk("avg_none_before_4", 32'(caps.size()), 32'd0);
        chk("avg_period_held", 32'(mon_if.period), 32'd0);
        gen(8, 8);
        gen(4, 4);
        chk("avg_count", 32'(caps.size()), 32'd2);
        if (caps.size() >= 2) begin
            chk("avg_p4", 32'(caps[0].p), 32'd10);
            chk("avg_h4", 32'(caps[0].h), 32'd6);
            chk("avg_p5", 32'(caps[1].p), 32'd12);
            chk("avg_h5", 32'(caps[1].h), 32'd8);
        end
        chk("avg_stalled", 32'(mon_if.stalled), 32'd0);
`else
        // Steady 5/5, duty 3/7, step 1/3, one 5/5, final rise then hold low.
        caps.delete();
        repeat (5) gen(5, 5);
        repeat (3) gen(3, 7);
        repeat (3) gen(1, 3);
        gen(5, 5);
        gen(5, 300);
        chk("run_count", 32'(caps.size()), 32'd12);
        for (int i = 0; i < 12 && i < caps.size(); i++) begin
            chk($sformatf("run_period[%0d]", i), 32'(caps[i].p), 32'(exp_p[i]));
            chk($sformatf("run_high[%0d]", i), 32'(caps[i].h), 32'(exp_h[i]));
        end
        for (int i = 1; i < 5 && i < caps.size(); i++) begin
            chk($sformatf("steady_spacing[%0d]", i), 32'(caps[i].c - caps[i-1].c), 32'd10);
        end
        chk("stalled_set", 32'(mon_if.stalled), 32'd1);
        if (caps.size() == 12) begin
            chk("stall_delay", 32'(stall_cyc - caps[11].c), 32'd255);
        end
        chk("stall_period_kept", 32'(mon_if.period), 32'd10);
        chk("stall_high_kept", 32'(mon_if.high_time), 32'd5);

        // Recovery: stalled clears with the first valid on the second rise.
        caps.delete();
        gen(5, 5);
        chk("recov_still_stalled", 32'(mon_if.stalled), 32'd1);
        chk("recov_no_valid_yet", 32'(caps.size()), 32'd0);
        gen(5, 5);
        gen(5, 5);
        chk("recov_stalled_clear", 32'(mon_if.stalled), 32'd0);
        chk("recov_count", 32'(caps.size()), 32'd2);
        for (int i = 0; i < 2 && i < caps.size(); i++) begin
            chk($sformatf("recov_period[%0d]", i), 32'(caps[i].p), 32'd10);
            chk($sformatf("recov_high[%0d]", i), 32'(caps[i].h), 32'd5);
        end

        // Sleep with a meas_clk rise inside the sleep window.
        caps.delete();
        gen(5, 3);
        chk("sleep_pre_count", 32'(caps.size()), 32'd1);
        sleep = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) meas_clk = 1'b1;
            @(negedge clk_in);
            chk("sleep_valid", 32'(mon_if.period_valid), 32'd0);
            chk("sleep_period", 32'(mon_if.period), 32'd10);
        end
        sleep = 1'b0;
        repeat (2) @(negedge clk_in);
        meas_clk = 1'b0;
        repeat (5) @(negedge clk_in);
        repeat (3) gen(5, 5);
        chk("sleep_post_count", 32'(caps.size()), 32'd3);
        for (int i = 1; i < 3 && i < caps.size(); i++) begin
            chk($sformatf("sleep_period[%0d]", i), 32'(caps[i].p), 32'd10);
            chk($sformatf("sleep_high[%0d]", i), 32'(caps[i].h), 32'd5);
        end
        chk("sleep_stalled", 32'(mon_if.stalled), 32'd0);

        // Reset pulse during MEASURE with meas_clk low.
        gen(5, 2);
        reset = 1'b0;
        @(negedge clk_in);
        chk("mrst_period", 32'(mon_if.period), 32'd0);
        chk("mrst_high", 32'(mon_if.high_time), 32'd0);
        chk("mrst_valid", 32'(mon_if.period_valid), 32'd0);
        chk("mrst_stalled", 32'(mon_if.stalled), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        caps.delete();
        gen(5, 5);
        chk("mrst_first_rise_silent", 32'(caps.size()), 32'd0);
        chk("mrst_period_held", 32'(mon_if.period), 32'd0);
        gen(5, 5);
        gen(5, 5);
        chk("mrst_count", 32'(caps.size()), 32'd2);
        for (int i = 0; i < 2 && i < caps.size(); i++) begin
            chk($sformatf("mrst_period[%0d]", i), 32'(caps[i].p), 32'd10);
            chk($sformatf("mrst_high[%0d]", i), 32'(caps[i].h), 32'd5);
        end
`endif

        repeat (2) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
